trace_mem_ctrl: RTL and testbench

//  Word memory directly downstream of the tracer. Trace mode (MODE_I=0): stores each tracer word in a

---
 rtl/trace_mem_ctrl_pkg.sv | 13 +
 rtl/trace_ram.sv | 26 ++
 rtl/trace_mem_ctrl.sv | 134 +++++++++++++
 tb/tb_trace_mem_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/trace_mem_ctrl_pkg.sv
// Shared sizes and state encoding for the trace memory controller.
// Imported by the controller top and its RAM.
package trace_mem_ctrl_pkg;
  localparam int TRB_WIDTH      = 32;
  localparam int TRB_DEPTH      = 64;
  localparam int TRB_DELAY_BITS = 16;

  typedef enum logic [1:0] {
    ARMED,
    DELAY,
    FROZEN
  } tmc_state_e;
endpackage

// File: rtl/trace_ram.sv
// Simple dual-port word RAM.
// One write port and one registered read port; contents are never reset.
module trace_ram
  import trace_mem_ctrl_pkg::*;
#(
  parameter int WIDTH = TRB_WIDTH,
  parameter int DEPTH = TRB_DEPTH,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             FPGA_CLK_I,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge FPGA_CLK_I) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/trace_mem_ctrl.sv
// Trace buffer / stream FIFO sitting between the tracer and the system bus.
// Trace mode freezes a circular buffer after a delayed trigger.
module trace_mem_ctrl
  import trace_mem_ctrl_pkg::*;
#(
  parameter int WIDTH      = TRB_WIDTH,
  parameter int DEPTH      = TRB_DEPTH,
  parameter int DELAY_BITS = TRB_DELAY_BITS,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic                  FPGA_CLK_I,
  input  logic                  RST_NI,
  input  logic                  EN_I,
  input  logic                  MODE_I,
  input  logic [DELAY_BITS-1:0] TRG_DELAY_I,
  input  logic                  TRG_EVENT_I,
  input  logic                  STORE_I,
  input  logic [WIDTH-1:0]      DATA_I,
  input  logic                  LOAD_I,
  output logic [WIDTH-1:0]      DATA_O,
  output logic                  LOAD_O,
  output logic                  TRG_EVENT_O,
  output logic [AW-1:0]         TRG_PTR_O,
  input  logic                  SYS_WE_I,
  input  logic [WIDTH-1:0]      SYS_WDATA_I,
  output logic                  SYS_FULL_O,
  input  logic                  SYS_RE_I,
  output logic [WIDTH-1:0]      SYS_RDATA_O,
  output logic                  SYS_VALID_O
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  tmc_state_e            state;
  logic                  mode_q;
  logic [AW-1:0]         wr_ptr, rd_ptr, trg_ptr;
  logic [AW:0]           count;
  logic [DELAY_BITS-1:0] delay_cnt;
  logic                  pending, load_q, sys_valid_q;

  logic             mode_chg, active, load_req, full;
  logic             t_sys_rd, t_load, t_store;
  logic             s_pop, s_push;
  logic [AW-1:0]    wr_nxt, raddr;
  logic [WIDTH-1:0] rdata;

  assign mode_chg = MODE_I != mode_q;
  assign active   = RST_NI && !mode_chg;
  assign load_req = LOAD_I || pending;
  assign full     = count == FULL_CNT;

  assign t_sys_rd = !mode_q && state == FROZEN && SYS_RE_I;
  assign t_load   = !mode_q && load_req && !t_sys_rd;
  assign t_store  = !mode_q && EN_I && STORE_I && state != FROZEN;
  assign wr_nxt   = wr_ptr + AW'(t_store);

  assign s_pop    = mode_q && load_req && count != '0;
  assign s_push   = mode_q && EN_I && SYS_WE_I && (!full || s_pop);

  // Stream pops and frozen readout walk rd_ptr; tracer loads peek wr_ptr.
  assign raddr = (t_sys_rd || mode_q) ? rd_ptr : wr_ptr;

  trace_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_ram (
    .FPGA_CLK_I (FPGA_CLK_I),
    .we         (active && (t_store || s_push)),
    .waddr      (wr_ptr),
    .wdata      (mode_q ? SYS_WDATA_I : DATA_I),
    .re         (active && (t_sys_rd || t_load || s_pop)),
    .raddr      (raddr),
    .rdata      (rdata)
  );

  always_ff @(posedge FPGA_CLK_I) begin
    if (!RST_NI || mode_chg) begin
      mode_q      <= MODE_I;
      state       <= ARMED;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      trg_ptr     <= '0;
      count       <= '0;
      delay_cnt   <= '0;
      pending     <= 1'b0;
      load_q      <= 1'b0;
      sys_valid_q <= 1'b0;
    end else begin
      load_q      <= t_load || s_pop;
      sys_valid_q <= t_sys_rd;
      if (mode_q) begin
        if (s_push) wr_ptr <= wr_ptr + AW'(1);
        if (s_pop) rd_ptr <= rd_ptr + AW'(1);
        if (load_req) pending <= count == '0;
        count <= count + (AW+1)'(s_push) - (AW+1)'(s_pop);
      end else begin
        pending <= load_req && t_sys_rd;
        if (t_sys_rd) rd_ptr <= rd_ptr + AW'(1);
        wr_ptr <= wr_nxt;
        unique case (state)
          ARMED: begin
            if (EN_I && TRG_EVENT_I) begin
              trg_ptr <= wr_ptr;
              if (TRG_DELAY_I == '0) begin
                state  <= FROZEN;
                rd_ptr <= wr_nxt;
              end else begin
                delay_cnt <= TRG_DELAY_I;
                state     <= DELAY;
              end
            end
          end
          DELAY: begin
            if (t_store) begin
              delay_cnt <= delay_cnt - DELAY_BITS'(1);
              if (delay_cnt == DELAY_BITS'(1)) begin
                state  <= FROZEN;
                rd_ptr <= wr_nxt;
              end
            end
          end
          FROZEN: state <= FROZEN;
          default: state <= ARMED;
        endcase
      end
    end
  end

  assign LOAD_O      = load_q;
  assign DATA_O      = load_q ? rdata : '0;
  assign SYS_VALID_O = sys_valid_q;
  assign SYS_RDATA_O = sys_valid_q ? rdata : '0;
  assign TRG_EVENT_O = state == FROZEN;
  assign TRG_PTR_O   = trg_ptr;
  assign SYS_FULL_O  = full;

endmodule

// File: tb/tb_trace_mem_ctrl.sv
// Directed bench for trace_mem_ctrl: trace capture, readout, stream FIFO.
// Inputs change on falling edges; outputs are checked on the next falling edge.
module tb_trace_mem_ctrl;
  import trace_mem_ctrl_pkg::*;

  localparam int W  = TRB_WIDTH;
  localparam int AW = $clog2(TRB_DEPTH);

  logic                      clk = 1'b0;
  logic                      rst_n, en, mode, trg, store, load, swe, sre;
  logic [TRB_DELAY_BITS-1:0] dly;
  logic [W-1:0]              din, swdata;
  logic [W-1:0]              dout, srdata;
  logic                      load_o, trg_o, full_o, svalid;
  logic [AW-1:0]             trg_ptr;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  trace_mem_ctrl dut (
    .FPGA_CLK_I  (clk),
    .RST_NI      (rst_n),
    .EN_I        (en),
    .MODE_I      (mode),
    .TRG_DELAY_I (dly),
    .TRG_EVENT_I (trg),
    .STORE_I     (store),
    .DATA_I      (din),
    .LOAD_I      (load),
    .DATA_O      (dout),
    .LOAD_O      (load_o),
    .TRG_EVENT_O (trg_o),
    .TRG_PTR_O   (trg_ptr),
    .SYS_WE_I    (swe),
    .SYS_WDATA_I (swdata),
    .SYS_FULL_O  (full_o),
    .SYS_RE_I    (sre),
    .SYS_RDATA_O (srdata),
    .SYS_VALID_O (svalid)
  );

  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    trg = 0; store = 0; load = 0; swe = 0; sre = 0;
    din = '0; swdata = '0; dly = '0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    step();
    rst_n = 1;
  endtask

  task automatic test_reset();
    idle_inputs();
    en = 1; mode = 0;
    rst_n = 0;
    step(); step();
    n_chk++; if (load_o !== 1'b0) begin n_fail++; $display("FAIL rst_load_o: got %b exp 0", load_o); end
    n_chk++; if (svalid !== 1'b0) begin n_fail++; $display("FAIL rst_sys_valid: got %b exp 0", svalid); end
    n_chk++; if (trg_o !== 1'b0) begin n_fail++; $display("FAIL rst_trg_o: got %b exp 0", trg_o); end
    n_chk++; if (trg_ptr !== '0) begin n_fail++; $display("FAIL rst_trg_ptr: got %0h exp 0", trg_ptr); end
    n_chk++; if (full_o !== 1'b0) begin n_fail++; $display("FAIL rst_full: got %b exp 0", full_o); end
    n_chk++; if (dout !== '0) begin n_fail++; $display("FAIL rst_data_o: got %0h exp 0", dout); end
    n_chk++; if (srdata !== '0) begin n_fail++; $display("FAIL rst_sys_rdata: got %0h exp 0", srdata); end
    rst_n = 1;
  endtask

  // Known background pattern 0x1000+addr so later readouts are fully defined.
  task automatic prefill();
    for (int i = 0; i < TRB_DEPTH; i++) begin
      store = 1; din = W'(32'h1000 + i);
      step();
    end
    store = 0;
    do_reset();
  endtask

  task automatic test_trigger_delay();
    dly = 3;
    for (int i = 0; i < 10; i++) begin
      store = 1; din = W'(i); trg = (i >= 4);
      step();
      if (i == 4) begin
        n_chk++; if (trg_ptr !== AW'(4)) begin n_fail++; $display("FAIL trg_ptr: got %0d exp 4", trg_ptr); end
      end
      if (i == 6) begin
        n_chk++; if (trg_o !== 1'b0) begin n_fail++; $display("FAIL trg_early: got %b exp 0", trg_o); end
      end
      if (i == 7) begin
        n_chk++; if (trg_o !== 1'b1) begin n_fail++; $display("FAIL trg_after7: got %b exp 1", trg_o); end
      end
    end
    store = 0; trg = 0;
  endtask

  task automatic test_readout();
    logic [W-1:0] exp;
    int a;
    for (int i = 0; i < TRB_DEPTH; i++) begin
      sre = 1;
      step();
      a = (8 + i) % TRB_DEPTH;
      exp = (a < 8) ? W'(a) : W'(32'h1000 + a);
      n_chk++;
      if (svalid !== 1'b1 || srdata !== exp) begin
        n_fail++;
        $display("FAIL readout[%0d]: got v=%b d=%0h exp v=1 d=%0h", i, svalid, srdata, exp);
      end
    end
    sre = 0;
    step();
    n_chk++; if (svalid !== 1'b0) begin n_fail++; $display("FAIL readout_pulse: got %b exp 0", svalid); end
    sre = 1; load = 1;
    step();
    sre = 0; load = 0;
    n_chk++; if (svalid !== 1'b1 || load_o !== 1'b0) begin n_fail++; $display("FAIL prio: got sv=%b lo=%b exp sv=1 lo=0", svalid, load_o); end
    n_chk++; if (srdata !== W'(32'h1008)) begin n_fail++; $display("FAIL prio_data: got %0h exp 1008", srdata); end
    step();
    n_chk++; if (load_o !== 1'b1 || dout !== W'(32'h1008)) begin n_fail++; $display("FAIL pending_load: got lo=%b d=%0h exp lo=1 d=1008", load_o, dout); end
    step();
    n_chk++; if (load_o !== 1'b0) begin n_fail++; $display("FAIL pending_pulse: got %b exp 0", load_o); end
  endtask

  task automatic test_reset_mid_delay();
    do_reset();
    dly = 5;
    store = 1; din = W'(32'h2F0); step();
    din = W'(32'h2F1); step();
    trg = 1; din = W'(32'h300); step();
    din = W'(32'h301); step();
    n_chk++; if (trg_ptr !== AW'(2)) begin n_fail++; $display("FAIL mid_trg_ptr: got %0d exp 2", trg_ptr); end
    store = 0; trg = 0;
    do_reset();
    n_chk++; if (trg_ptr !== '0 || trg_o !== 1'b0) begin n_fail++; $display("FAIL mid_rst: got p=%0d t=%b exp p=0 t=0", trg_ptr, trg_o); end
    for (int i = 0; i < 5; i++) begin
      store = 1; din = W'(32'h310 + i);
      step();
    end
    store = 0;
    step();
    n_chk++; if (trg_o !== 1'b0) begin n_fail++; $display("FAIL mid_armed: got %b exp 0", trg_o); end
    sre = 1; step(); sre = 0;
    n_chk++; if (svalid !== 1'b0) begin n_fail++; $display("FAIL sre_not_frozen: got %b exp 0", svalid); end
  endtask

  task automatic test_delay_zero();
    do_reset();
    dly = 0; trg = 1; store = 1; din = W'(32'hBEEF);
    step();
    trg = 0;
    n_chk++; if (trg_o !== 1'b1 || trg_ptr !== '0) begin n_fail++; $display("FAIL dz_trg: got t=%b p=%0d exp t=1 p=0", trg_o, trg_ptr); end
    din = W'(32'hDEAD);
    step();
    store = 0;
    for (int i = 0; i < TRB_DEPTH; i++) begin
      sre = 1;
      step();
      if (i == 0) begin
        n_chk++; if (srdata !== W'(32'h311)) begin n_fail++; $display("FAIL dz_first: got %0h exp 311", srdata); end
      end
      if (i == TRB_DEPTH - 1) begin
        n_chk++; if (srdata !== W'(32'hBEEF)) begin n_fail++; $display("FAIL dz_last: got %0h exp beef", srdata); end
      end
    end
    sre = 0;
  endtask

  task automatic test_stream_basic();
    mode = 1;
    step();
    n_chk++; if (trg_o !== 1'b0 || full_o !== 1'b0) begin n_fail++; $display("FAIL st_enter: got t=%b f=%b exp 0 0", trg_o, full_o); end
    load = 1; sre = 1; trg = 1;
    step();
    load = 0; sre = 0; trg = 0;
    n_chk++; if (load_o !== 1'b0 || svalid !== 1'b0) begin n_fail++; $display("FAIL st_empty: got lo=%b sv=%b exp 0 0", load_o, svalid); end
    swe = 1; swdata = W'(32'hA5);
    step();
    swe = 0;
    n_chk++; if (load_o !== 1'b0) begin n_fail++; $display("FAIL st_nofall: got %b exp 0", load_o); end
    step();
    n_chk++; if (load_o !== 1'b1 || dout !== W'(32'hA5)) begin n_fail++; $display("FAIL st_pop: got lo=%b d=%0h exp 1 a5", load_o, dout); end
    step();
    n_chk++; if (load_o !== 1'b0) begin n_fail++; $display("FAIL st_pulse: got %b exp 0", load_o); end
  endtask

  task automatic test_stream_full();
    logic [W-1:0] exp;
    for (int i = 0; i < TRB_DEPTH; i++) begin
      swe = 1; swdata = W'(32'h200 + i);
      step();
      if (i == TRB_DEPTH - 2) begin
        n_chk++; if (full_o !== 1'b0) begin n_fail++; $display("FAIL full_early: got %b exp 0", full_o); end
      end
    end
    n_chk++; if (full_o !== 1'b1) begin n_fail++; $display("FAIL full: got %b exp 1", full_o); end
    swdata = W'(32'h2FF);
    step();
    swe = 1; load = 1; swdata = W'(32'h240);
    step();
    swe = 0;
    n_chk++; if (load_o !== 1'b1 || dout !== W'(32'h200)) begin n_fail++; $display("FAIL pushpop: got lo=%b d=%0h exp 1 200", load_o, dout); end
    n_chk++; if (full_o !== 1'b1) begin n_fail++; $display("FAIL pushpop_full: got %b exp 1", full_o); end
    for (int i = 0; i < TRB_DEPTH; i++) begin
      step();
      exp = (i < TRB_DEPTH - 1) ? W'(32'h201 + i) : W'(32'h240);
      n_chk++;
      if (load_o !== 1'b1 || dout !== exp) begin
        n_fail++;
        $display("FAIL drain[%0d]: got lo=%b d=%0h exp lo=1 d=%0h", i, load_o, dout, exp);
      end
    end
    n_chk++; if (full_o !== 1'b0) begin n_fail++; $display("FAIL drained_full: got %b exp 0", full_o); end
    step();
    load = 0;
    n_chk++; if (load_o !== 1'b0) begin n_fail++; $display("FAIL drained_load: got %b exp 0", load_o); end
  endtask

  task automatic test_mode_toggle();
    swe = 1; swdata = W'(32'h77);
    step();
    swe = 0; mode = 0;
    step();
    n_chk++; if (load_o !== 1'b0) begin n_fail++; $display("FAIL tog_stale: got %b exp 0", load_o); end
    n_chk++; if (trg_o !== 1'b0 || full_o !== 1'b0) begin n_fail++; $display("FAIL tog_outs: got t=%b f=%b exp 0 0", trg_o, full_o); end
    mode = 1;
    step();
    en = 0; load = 1; swe = 1; swdata = W'(32'h88);
    step();
    en = 1; load = 0; swe = 0;
    n_chk++; if (load_o !== 1'b0) begin n_fail++; $display("FAIL en_load0: got %b exp 0", load_o); end
    step();
    n_chk++; if (load_o !== 1'b0) begin n_fail++; $display("FAIL en_push: got %b exp 0", load_o); end
  endtask

  initial begin
    test_reset();
    prefill();
    test_trigger_delay();
    test_readout();
    test_reset_mid_delay();
    test_delay_zero();
    test_stream_basic();
    test_stream_full();
    test_mode_toggle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
